display_scroll_ctrl: RTL and testbench

//  Sequencer for the 5-to-1 character mux / 7-segment decoder datapath.

---
 rtl/display_pkg.sv | 23 ++
 rtl/display_scroll_ctrl_if.sv | 27 ++
 rtl/display_scroll_ctrl_tick_prescaler.sv | 41 ++++
 rtl/display_scroll_ctrl.sv | 133 +++++++++++++
 tb/tb_display_scroll_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the character-rotation display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding for the scroll sequencer, default character
// count, and the active-low 7-segment codes used by the mux/decoder stage.
package display_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam int DEFAULT_NUM_CHARS = 5;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_scroll_ctrl_if.sv
// Board-side control and mux-select bundle for the scroll sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
//
// Signals: run, dir, step (board -> sequencer); sel, tick, wrap, running
// (sequencer -> mux). The slave modport is the sequencer's view.
interface display_scroll_ctrl_if #(
  parameter int SEL_W = 3
);
  logic             run;
  logic             dir;
  logic             step;
  logic [SEL_W-1:0] sel;
  logic             tick;
  logic             wrap;
  logic             running;

  modport master (
    output run, dir, step,
    input  sel, tick, wrap, running
  );

  modport slave (
    input  run, dir, step,
    output sel, tick, wrap, running
  );
endinterface

// File: rtl/display_scroll_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV cycle counter with terminal-count flag.
// Latency: tc is combinational from the count register; count updates next edge.
// Backpressure: none; en stalls counting, clr forces the count to zero.
//
// Ports: clk, resetn (async active-low), clr (sync clear, wins over en),
// en (count enable), tc (high in the cycle the count sits at TICK_DIV-1 while enabled).
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scroll_ctrl.sv
// Rotating select sequencer for the character mux (run/stop, up/down, optional step).
// Latency: first advance TICK_DIV cycles after entering RUNNING; step advance 3 edges after press.
// Backpressure: none; run=0 stops rotation immediately and beats a coincident terminal count.
//
// Ports: clk, resetn (async active-low), bus (slave modport: run, dir, step in;
// sel, tick, wrap, running out). All outputs come straight from flops.
// Optional feature macro: SCROLL_STEP_EN (pushbutton single-step while stopped).
module display_scroll_ctrl
  import display_pkg::*;
#(
  parameter int NUM_CHARS = DEFAULT_NUM_CHARS,
  parameter int SEL_W     = 3,
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 26
) (
  input  logic                 clk,
  input  logic                 resetn,
  display_scroll_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHARS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             tick_q,  tick_d;
  logic             wrap_q,  wrap_d;

  logic run_en;
  logic tc;
  logic step_adv;
  logic adv;

  // Prescaler only counts while RUNNING and run is still asserted, so a
  // stop request clears it in the same edge that would have advanced.
  assign run_en = (state_q == ST_RUNNING) && bus.run;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!run_en),
    .en     (run_en),
    .tc     (tc)
  );

`ifdef SCROLL_STEP_EN
  // Two flops for metastability, a third remembers the previous synced level.
  logic step_s1_q, step_s1_d;
  logic step_s2_q, step_s2_d;
  logic step_s3_q, step_s3_d;

  always_comb begin
    step_s1_d = bus.step;
    step_s2_d = step_s1_q;
    step_s3_d = step_s2_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
    end else begin
      step_s1_q <= step_s1_d;
      step_s2_q <= step_s2_d;
      step_s3_q <= step_s3_d;
    end
  end

  assign step_adv = step_s2_q && !step_s3_q && (state_q == ST_STOPPED);
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign step_adv    = 1'b0;
`endif

  assign adv = tc || step_adv;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      ST_STOPPED: if (bus.run)  state_d = ST_RUNNING;
      ST_RUNNING: if (!bus.run) state_d = ST_STOPPED;
      default:                  state_d = ST_STOPPED;
    endcase

    // dir is only looked at here, on the advancing edge.
    if (adv) begin
      tick_d = 1'b1;
      if (bus.dir) begin
        if (sel_q == '0) begin
          sel_d  = LAST_SEL;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q - 1'b1;
        end
      end else begin
        if (sel_q >= LAST_SEL) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_STOPPED;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Directed bench for display_scroll_ctrl: one DUT at TICK_DIV=4, one at TICK_DIV=1.
// Observed word per DUT is {running, tick, wrap, sel[2:0]}; expectations are hand-derived.
// Step behaviour is exercised with SCROLL_STEP_EN, otherwise step must be ignored.
module tb_display_scroll_ctrl;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  display_scroll_ctrl_if #(.SEL_W(3)) ifa ();
  display_scroll_ctrl_if #(.SEL_W(3)) ifb ();

  display_scroll_ctrl #(
    .NUM_CHARS (5), .SEL_W (3), .TICK_DIV (4), .CNT_W (3)
  ) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifa)
  );

  display_scroll_ctrl #(
    .NUM_CHARS (5), .SEL_W (3), .TICK_DIV (1), .CNT_W (1)
  ) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [5:0] obs_a();
    return {ifa.running, ifa.tick, ifa.wrap, ifa.sel};
  endfunction

  function automatic logic [5:0] obs_b();
    return {ifb.running, ifb.tick, ifb.wrap, ifb.sel};
  endfunction

  function automatic logic [5:0] mk(input logic r, input logic t, input logic w, input int s);
    return {r, t, w, 3'(s)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    resetn = 1'b1;
    ifa.run = 1'b1; ifa.dir = 1'b0; ifa.step = 1'b0;
    ifb.run = 1'b1; ifb.dir = 1'b0; ifb.step = 1'b0;
    #2 resetn = 1'b0;
    #1;
    e = mk(0, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL reset_async_a: got %h expected %h", obs_a(), e); end
    n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL reset_async_b: got %h expected %h", obs_b(), e); end
    repeat (3) cyc();
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL reset_held_a: got %h expected %h", obs_a(), e); end
    n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL reset_held_b: got %h expected %h", obs_b(), e); end
    ifa.run = 1'b0;
    ifb.run = 1'b0;
    resetn  = 1'b1;
    cyc();
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL reset_release_a: got %h expected %h", obs_a(), e); end
  endtask

  task automatic test_up_rotation();
    logic [5:0] e;
    int prev;
    ifa.dir = 1'b0;
    ifa.run = 1'b1;
    cyc();
    e = mk(1, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL up_enter: got %h expected %h", obs_a(), e); end
    prev = 0;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        e = mk(1, 0, 0, prev);
        n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL up_idle k=%0d j=%0d: got %h expected %h", k, j, obs_a(), e); end
      end
      cyc();
      e = mk(1, 1, (k == 5), k % 5);
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL up_adv k=%0d: got %h expected %h", k, obs_a(), e); end
      prev = k % 5;
    end
  endtask

  task automatic test_down_rotation();
    int seq [5] = '{4, 3, 2, 1, 0};
    logic [5:0] e;
    int prev;
    ifa.dir = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        e = mk(1, 0, 0, prev);
        n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL down_idle k=%0d j=%0d: got %h expected %h", k, j, obs_a(), e); end
      end
      cyc();
      e = mk(1, 1, (k == 0), seq[k]);
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL down_adv k=%0d: got %h expected %h", k, obs_a(), e); end
      prev = seq[k];
    end
  endtask

  task automatic test_stop_resume();
    logic [5:0] e;
    ifa.dir = 1'b0;
    repeat (3) cyc();
    // Prescaler now sits at its terminal value; dropping run must win.
    ifa.run = 1'b0;
    cyc();
    e = mk(0, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL stop_on_tc: got %h expected %h", obs_a(), e); end
    for (int j = 0; j < 3; j++) begin
      cyc();
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL stop_hold j=%0d: got %h expected %h", j, obs_a(), e); end
    end
    ifa.run = 1'b1;
    cyc();
    e = mk(1, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL resume_enter: got %h expected %h", obs_a(), e); end
    for (int j = 0; j < 3; j++) begin
      cyc();
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL resume_idle j=%0d: got %h expected %h", j, obs_a(), e); end
    end
    cyc();
    e = mk(1, 1, 0, 1);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL resume_adv: got %h expected %h", obs_a(), e); end
    ifa.run = 1'b0;
    cyc();
    e = mk(0, 0, 0, 1);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL resume_stop: got %h expected %h", obs_a(), e); end
  endtask

  task automatic test_tick_div1();
    logic [5:0] e;
    ifb.dir = 1'b0;
    ifb.run = 1'b1;
    cyc();
    e = mk(1, 0, 0, 0);
    n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL div1_enter: got %h expected %h", obs_b(), e); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      e = mk(1, 1, (k == 5), k % 5);
      n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL div1_adv k=%0d: got %h expected %h", k, obs_b(), e); end
    end
    ifb.run = 1'b0;
    cyc();
    e = mk(0, 0, 0, 0);
    n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL div1_stop: got %h expected %h", obs_b(), e); end
  endtask

`ifdef SCROLL_STEP_EN
  task automatic test_step();
    logic [5:0] e;
    int s;
    // DUT A is stopped at sel=1, dir=0. Two presses: 1->2, then 2->3.
    for (int p = 0; p < 2; p++) begin
      ifa.step = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        cyc();
        s = (k >= 3) ? 2 + p : 1 + p;
        e = mk(0, (k == 3), 0, s);
        n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL step_press p=%0d k=%0d: got %h expected %h", p, k, obs_a(), e); end
      end
      ifa.step = 1'b0;
      repeat (3) cyc();
    end
    // While running, a press must not add an advance.
    ifa.run = 1'b1;
    cyc();
    ifa.step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      s = (k < 4) ? 3 : (k < 8) ? 4 : 0;
      e = mk(1, (k % 4 == 0), (k == 8), s);
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL step_running k=%0d: got %h expected %h", k, obs_a(), e); end
    end
    ifa.step = 1'b0;
    ifa.run  = 1'b0;
    cyc();
    e = mk(0, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL step_run_stop: got %h expected %h", obs_a(), e); end
    repeat (3) cyc();
  endtask
`else
  task automatic test_step();
    logic [5:0] e;
    ifa.step = 1'b1;
    e = mk(0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL step_ignored k=%0d: got %h expected %h", k, obs_a(), e); end
    end
    ifa.step = 1'b0;
    cyc();
  endtask
`endif

  task automatic test_reset_mid();
    logic [5:0] e;
    ifa.dir = 1'b0;
    ifa.run = 1'b1;
    repeat (5) cyc();
    // Just after an advance edge: tick is high and sel is nonzero.
    #3 resetn = 1'b0;
    #1;
    e = mk(0, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL midreset_a: got %h expected %h", obs_a(), e); end
    n_cmp++; if (obs_b() !== e) begin n_bad++; $display("FAIL midreset_b: got %h expected %h", obs_b(), e); end
    cyc();
    resetn = 1'b1;
    cyc();
    e = mk(1, 0, 0, 0);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL midreset_enter: got %h expected %h", obs_a(), e); end
    repeat (3) cyc();
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL midreset_idle: got %h expected %h", obs_a(), e); end
    cyc();
    e = mk(1, 1, 0, 1);
    n_cmp++; if (obs_a() !== e) begin n_bad++; $display("FAIL midreset_first_adv: got %h expected %h", obs_a(), e); end
    ifa.run = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_up_rotation();
    test_down_rotation();
    test_stop_resume();
    test_tick_div1();
    test_step();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
